press_classifier: RTL and testbench
===================================

PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 Parameter LONG_TICKS, default 50000000, hold cycles before a press counts as long (1 s at 50 MHz); SHALL be >= 2.
REQ-002 Parameter REPEAT_TICKS, default 10000000, cycles between auto-repeat steps while held long (200 ms); SHALL be >= 1.
REQ-003 Parameter CNT_W, default 26, hold-timer width; SHALL hold max(LONG_TICKS, REPEAT_TICKS).
REQ-004 clk_i  input  1  system clock (50 MHz generator); single clock domain, all logic on rising edge.
REQ-005 rst_i  input  1  asynchronous, active-low reset.
REQ-006 sw_state_i  input  1  debounced button level from the debouncer, 1 = pressed; already synchronous to clk_i.
REQ-007 press_o  output  1  one-cycle pulse on press.
REQ-008 short_o  output  1  one-cycle pulse on release before the long threshold.
REQ-009 long_o  output  1  one-cycle pulse when hold reaches LONG_TICKS.
REQ-010 repeat_o  output  1  one-cycle auto-repeat pulse while held long.
REQ-011 step_o  output  1  press_o OR repeat_o; drives a downstream counter's increment.
REQ-012 held_o  output  1  level, 1 while FSM is not IDLE.

Function
REQ-013 All outputs SHALL be registered; no combinational path from sw_state_i to any output.
REQ-014 FSM states SHALL be IDLE, PRESSED, LONG_HELD.
REQ-015 Press edge: sw_state_i sampled 1 while previous sample 0 at the edge beginning cycle P; FSM IDLE->PRESSED, press_o high in cycle P only, timer cleared.
REQ-016 In PRESSED the timer SHALL increment each cycle; while still held, long_o and repeat_o SHALL both pulse in cycle P+LONG_TICKS and FSM SHALL move to LONG_HELD.
REQ-017 In LONG_HELD, repeat_o SHALL pulse in cycles P+LONG_TICKS+n*REPEAT_TICKS, n = 1, 2, ...; long_o SHALL not pulse again.
REQ-018 Release: sw_state_i sampled 0 at the edge beginning cycle R; FSM SHALL go to IDLE in R.
REQ-019 Release from PRESSED with R <= P+LONG_TICKS SHALL pulse short_o in cycle R; release wins at R = P+LONG_TICKS (short_o, no long_o, no repeat_o).
REQ-020 Release from LONG_HELD SHALL produce no short_o; a repeat due in cycle R SHALL be suppressed.
REQ-021 A new press may be detected in the cycle after R; no dead time beyond that.
REQ-022 Timer SHALL never wrap while held: it reloads on every repeat and stops in IDLE.
REQ-023 At most one of press_o, short_o, and long_o SHALL be high in any cycle; long_o always coincides with repeat_o.
REQ-024 held_o SHALL be high from cycle P through cycle R-1 inclusive.

Reset
REQ-025 While rst_i = 0: FSM IDLE, timer 0, previous-sample register 0, all outputs 0, applied immediately without waiting for a clock.
REQ-026 If sw_state_i = 1 when rst_i deasserts, the first sampling edge SHALL count as a press edge (press_o per REQ-015).
REQ-027 Reset asserted mid-operation SHALL abort with no short_o or long_o emitted.

Verification (LONG_TICKS=8, REPEAT_TICKS=3)
REQ-028 Reset: rst_i=0 with sw_state_i toggling -> all outputs 0 throughout; after release with sw_state_i=0 -> outputs stay 0.
REQ-029 Short press: sw_state_i=1 for 5 clocks -> press_o/step_o in P, short_o in P+5, no long_o or repeat_o, held_o high P..P+4.
REQ-030 Threshold race: held exactly 8 clocks -> short_o in P+8, no long_o; held 9 clocks -> long_o+repeat_o in P+8, no short_o.
REQ-031 Long hold 20 clocks -> long_o at P+8, repeat_o at P+8, P+11, P+14, P+17; step_o at P, P+8, P+11, P+14, P+17; no short_o at release P+20.
REQ-032 Reset mid LONG_HELD (at P+12) with button still held -> outputs 0 at once; on deassert, press_o on the next sampling edge and timing restarts from there.
REQ-033 Back-to-back: release then re-press after 1 low clock -> second press_o detected, each press classified independently.

Source files
------------

// File: rtl/press_classifier.sv
// Classifies a debounced button level into press, short, long and auto-repeat
// pulses. Every output leaves a flop, so sw_state_i never reaches a pin combinationally.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | button released, timer parked at 0, waiting for a rising level
// PRESSED   | held, counting toward the long threshold
// LONG_HELD | held past the long threshold, emitting auto-repeat steps

module press_classifier #(
    parameter int LONG_TICKS   = 50000000,
    parameter int REPEAT_TICKS = 10000000,
    parameter int CNT_W        = 26
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_state_i,
    output logic press_o,
    output logic short_o,
    output logic long_o,
    output logic repeat_o,
    output logic step_o,
    output logic held_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    // The timer starts at 0 in the cycle after a press or repeat, so the
    // terminal count sits one below the tick count.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE   = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_d;
    logic             sw_prev_q;
    logic             press_d;
    logic             short_d;
    logic             long_d;
    logic             repeat_d;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        press_d  = 1'b0;
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (sw_state_i && !sw_prev_q) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end
            end

            PRESSED: begin
                // Release is tested first so it wins the race at the threshold.
                if (!sw_state_i) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                    timer_d = '0;
                end else if (timer_q == LONG_LAST) begin
                    state_d  = LONG_HELD;
                    long_d   = 1'b1;
                    repeat_d = 1'b1;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            LONG_HELD: begin
                if (!sw_state_i) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            sw_prev_q <= 1'b0;
            press_o   <= 1'b0;
            short_o   <= 1'b0;
            long_o    <= 1'b0;
            repeat_o  <= 1'b0;
            step_o    <= 1'b0;
            held_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            sw_prev_q <= sw_state_i;
            press_o   <= press_d;
            short_o   <= short_d;
            long_o    <= long_d;
            repeat_o  <= repeat_d;
            step_o    <= press_d | repeat_d;
            held_o    <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_press_classifier.sv
// Randomized and directed stimulus for press_classifier, scored against a
// hold-duration model that derives each pulse from cycles elapsed since the press.

module tb_press_classifier;

    localparam int L = 8;
    localparam int R = 3;

    logic clk_i = 1'b0;
    logic rst_i;
    logic sw_state_i;
    logic press_o, short_o, long_o, repeat_o, step_o, held_o;

    int checks = 0;
    int errors = 0;

    // Model state: whether a press is in progress, its start cycle, last sample.
    int   cyc = 0;
    bit   active = 1'b0;
    int   p_cyc = 0;
    bit   prev = 1'b0;
    logic [5:0] exp_v;

    press_classifier #(
        .LONG_TICKS  (L),
        .REPEAT_TICKS(R),
        .CNT_W       (4)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .sw_state_i(sw_state_i),
        .press_o   (press_o),
        .short_o   (short_o),
        .long_o    (long_o),
        .repeat_o  (repeat_o),
        .step_o    (step_o),
        .held_o    (held_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [5:0] outs();
        return {press_o, short_o, long_o, repeat_o, step_o, held_o};
    endfunction

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got psLrSh=%b want %b", tag, cyc, got, want);
        end
    endtask

    // Expected outputs for the cycle that begins at this edge, given sample s.
    task automatic model_step(input bit s);
        bit pr, sh, lg, rp, hd;
        int k;
        pr = 0; sh = 0; lg = 0; rp = 0; hd = 0;
        cyc++;
        if (!rst_i) begin
            active = 0;
            prev   = 0;
        end else begin
            if (!active) begin
                if (s && !prev) begin
                    active = 1;
                    p_cyc  = cyc;
                    pr     = 1;
                    hd     = 1;
                end
            end else begin
                k = cyc - p_cyc;
                if (!s) begin
                    active = 0;
                    sh     = (k <= L);
                end else begin
                    hd = 1;
                    lg = (k == L);
                    rp = (k >= L) && (((k - L) % R) == 0);
                end
            end
            prev = s;
        end
        exp_v = {pr, sh, lg, rp, pr | rp, hd};
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick(input bit s);
        sw_state_i = s;
        @(posedge clk_i);
        model_step(s);
        #1 chk("cycle", outs(), exp_v);
        @(negedge clk_i);
    endtask

    task automatic hold(input int n_hi, input int n_lo);
        for (int i = 0; i < n_hi; i++) tick(1'b1);
        for (int i = 0; i < n_lo; i++) tick(1'b0);
    endtask

    task automatic assert_reset();
        rst_i = 1'b0;
        #1 chk("async_rst", outs(), 6'b0);
        active = 0;
        prev   = 0;
    endtask

    initial begin
        rst_i      = 1'b0;
        sw_state_i = 1'b0;
        @(negedge clk_i);
        #1 chk("reset_state", outs(), 6'b0);

        // Button activity while in reset must produce nothing.
        for (int i = 0; i < 6; i++) tick(1'(i & 1));
        rst_i = 1'b1;
        hold(0, 4);

        hold(5, 3);           // short press
        hold(8, 3);           // release exactly at the threshold -> short
        hold(9, 3);           // one more cycle -> long
        hold(20, 3);          // long with repeats

        // Reset while long-held, button kept down through and after reset.
        hold(13, 0);
        assert_reset();
        tick(1'b1);
        tick(1'b1);
        rst_i = 1'b1;
        hold(12, 2);

        // Back-to-back presses separated by a single low cycle.
        hold(4, 1);
        hold(10, 1);
        hold(3, 3);

        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 19) == 0) begin
                assert_reset();
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) tick(1'($urandom_range(0, 1)));
                rst_i = 1'b1;
            end
            hold(int'($urandom_range(1, 25)), int'($urandom_range(1, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
